// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the MEM pipeline stage
//
// Purpose: access-size codes, MEM stage state encoding, the no-write byte
//          enable constant and the store byte-enable helper.
// Ports:   none (package).

package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [3:0] WEN_NONE = 4'b0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // Byte enables for a store. Half uses a[1] only, so a misaligned half
    // lands on the half containing the address. Unused size code 11 is
    // treated as a word.
    function automatic logic [3:0] store_wen(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] wen;
        case (size)
            SIZE_B:  wen = 4'b0001 << addr_lo;
            SIZE_H:  wen = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: wen = 4'b1111;
        endcase
        return wen;
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load data lane select and sign/zero extension
//
// Purpose: picks the addressed byte/half out of a read word and extends it.
// Ports:
//   rdata    in  32  raw word from the data bus
//   addr_lo  in   2  low effective-address bits
//   size     in   2  SIZE_B / SIZE_H / SIZE_W
//   uns      in   1  zero-extend when 1, sign-extend when 0
//   data     out 32  aligned, extended load result

module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'b00:   byte_v = rdata[7:0];
            2'b01:   byte_v = rdata[15:8];
            2'b10:   byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (size)
            SIZE_B:  data = {{24{~uns & byte_v[7]}}, byte_v};
            SIZE_H:  data = {{16{~uns & half_v[15]}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data bus access, load align, stall
//
// Purpose: issues loads/stores with a req/ack handshake, stalls upstream
//          while an access is outstanding, aborts after TIMEOUT request
//          cycles without ack, and forms the writeback triple for reg_mem_wb.
// Configuration: MEM_MISALIGN_TRAP_EN adds the misalign output and suppresses
//          misaligned half/word accesses instead of issuing them.
// Ports:
//   clk, rst_n                              clock, async active-low reset
//   ex_have_inst/ex_pc/ex_we/ex_wr/ex_alu   instruction from EX/MEM
//   ex_ld/ex_st/ex_size/ex_uns/ex_sd        memory op description
//   dbus_req/dbus_wen/dbus_addr/dbus_wdata  data bus request side
//   dbus_ack/dbus_rdata                     data bus response side
//   mem_stall                               freezes IF..EX/MEM
//   bus_err                                 one-cycle timeout abort pulse
//   mem_we/mem_wd/mem_wr/mem_pc/mem_have_inst  to reg_mem_wb
//   misalign (MEM_MISALIGN_TRAP_EN only)    misaligned access flagged

module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_have_inst,
    input  logic [31:0] ex_pc,
    input  logic        ex_we,
    input  logic [4:0]  ex_wr,
    input  logic [31:0] ex_alu,
    input  logic        ex_ld,
    input  logic        ex_st,
    input  logic [1:0]  ex_size,
    input  logic        ex_uns,
    input  logic [31:0] ex_sd,
    output logic        dbus_req,
    output logic [3:0]  dbus_wen,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        mem_stall,
    output logic        bus_err,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    output logic [4:0]  mem_wr,
    output logic [31:0] mem_pc,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        mem_have_inst
);

    mem_state_t       state;
    logic [CNT_W-1:0] cnt;

    logic        act;
    logic        mop;
    logic        mis_hit;
    logic        req;
    logic        ack;
    logic        abort;
    logic        done;
    logic [31:0] ld_data;

    // Gating with rst_n keeps every bus/pipeline strobe low while reset is
    // held, even if EX/MEM still presents a memory op.
    assign act = rst_n & ex_have_inst;
    assign mop = act & (ex_ld | ex_st);

`ifdef MEM_MISALIGN_TRAP_EN
    assign mis_hit = mop & (((ex_size == SIZE_H) & ex_alu[0]) |
                            ((ex_size == SIZE_W) & (ex_alu[1:0] != 2'b00)));
    assign misalign = mis_hit;
`else
    assign mis_hit = 1'b0;
`endif

    assign req   = mop & ~mis_hit;
    assign ack   = req & dbus_ack;
    // Only reachable in WAIT: TIMEOUT >= 2 means the first request cycle
    // can never be the last.
    assign abort = req & (state == ST_WAIT) & ~dbus_ack &
                   (cnt == CNT_W'(TIMEOUT - 1));
    assign done  = ack | abort | mis_hit;

    // Bus request side. Address/data stay stable across WAIT because the
    // stall freezes the EX/MEM register feeding them.
    assign dbus_req  = req;
    assign dbus_addr = {ex_alu[31:2], 2'b00};
    assign dbus_wen  = (req & ex_st) ? store_wen(ex_size, ex_alu[1:0]) : WEN_NONE;

    always_comb begin
        case (ex_size)
            SIZE_B:  dbus_wdata = {4{ex_sd[7:0]}};
            SIZE_H:  dbus_wdata = {2{ex_sd[15:0]}};
            default: dbus_wdata = ex_sd;
        endcase
    end

    load_align u_load_align (
        .rdata   (dbus_rdata),
        .addr_lo (ex_alu[1:0]),
        .size    (ex_size),
        .uns     (ex_uns),
        .data    (ld_data)
    );

    assign mem_stall = req & ~dbus_ack & ~abort;
    assign bus_err   = abort;

    // Non-memory ops pass straight through; memory ops show a bubble until
    // they finish (ack, abort, or misalign trap).
    assign mem_have_inst = mop ? done : act;
    assign mem_we        = mop ? (ack & ex_ld & ex_we) : (act & ex_we);
    assign mem_wd        = (mop & ex_ld) ? ld_data : ex_alu;
    assign mem_wr        = ex_wr;
    assign mem_pc        = ex_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req & ~dbus_ack) begin
                        state <= ST_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                default: begin
                    // Leaving WAIT without req is defensive: upstream should
                    // be frozen, but never hold a stale count.
                    if (~req | dbus_ack | abort) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage

module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_have_inst;
    logic [31:0] ex_pc;
    logic        ex_we;
    logic [4:0]  ex_wr;
    logic [31:0] ex_alu;
    logic        ex_ld;
    logic        ex_st;
    logic [1:0]  ex_size;
    logic        ex_uns;
    logic [31:0] ex_sd;
    logic        dbus_req;
    logic [3:0]  dbus_wen;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        mem_stall;
    logic        bus_err;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [4:0]  mem_wr;
    logic [31:0] mem_pc;
    logic        mem_have_inst;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] wd;
        logic        we;
        logic [4:0]  wr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_have_inst  (ex_have_inst),
        .ex_pc         (ex_pc),
        .ex_we         (ex_we),
        .ex_wr         (ex_wr),
        .ex_alu        (ex_alu),
        .ex_ld         (ex_ld),
        .ex_st         (ex_st),
        .ex_size       (ex_size),
        .ex_uns        (ex_uns),
        .ex_sd         (ex_sd),
        .dbus_req      (dbus_req),
        .dbus_wen      (dbus_wen),
        .dbus_addr     (dbus_addr),
        .dbus_wdata    (dbus_wdata),
        .dbus_ack      (dbus_ack),
        .dbus_rdata    (dbus_rdata),
        .mem_stall     (mem_stall),
        .bus_err       (bus_err),
        .mem_we        (mem_we),
        .mem_wd        (mem_wd),
        .mem_wr        (mem_wr),
        .mem_pc        (mem_pc),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign      (misalign),
`endif
        .mem_have_inst (mem_have_inst)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] wd, input logic we,
                        input logic [4:0] wr, input logic [31:0] pc);
        exp_t e;
        e.wd = wd; e.we = we; e.wr = wr; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic set_op(input logic ld, input logic st, input logic [1:0] size,
                          input logic uns, input logic [31:0] alu,
                          input logic [31:0] sd, input logic we,
                          input logic [4:0] wr, input logic [31:0] pc);
        ex_have_inst = 1'b1;
        ex_ld = ld; ex_st = st; ex_size = size; ex_uns = uns;
        ex_alu = alu; ex_sd = sd; ex_we = we; ex_wr = wr; ex_pc = pc;
    endtask

    task automatic idle_inputs();
        ex_have_inst = 1'b0; ex_ld = 1'b0; ex_st = 1'b0;
        dbus_ack = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one access until ack arrives on request cycle ack_at.
    task automatic mem_access(input int ack_at, input logic [31:0] rdata);
        for (int k = 1; k <= ack_at; k++) begin
            dbus_ack = (k == ack_at);
            dbus_rdata = rdata;
            #1;
            check("req", dbus_req, 1);
            check("stall", mem_stall, (k != ack_at) ? 1 : 0);
            if (k != ack_at) check("bubble_have_inst", mem_have_inst, 0);
            next_cycle();
        end
        idle_inputs();
    endtask

    // Scoreboard monitor: every presented instruction must match the queue.
    always @(negedge clk) begin
        if (rst_n && mem_have_inst) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h wd %h expected nothing", mem_pc, mem_wd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_we", mem_we, e.we);
                if (e.we) check("sb_wd", mem_wd, e.wd);
                check("sb_wr", mem_wr, e.wr);
                check("sb_pc", mem_pc, e.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        dbus_rdata = 32'h0;
        idle_inputs();
        // Reset held with a load presented: nothing may leak out.
        set_op(1, 0, 2'b10, 0, 32'h100, 0, 1, 5'd1, 32'h0);
        #3;
        check("rst_req", dbus_req, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_err", bus_err, 0);
        check("rst_we", mem_we, 0);
        check("rst_have_inst", mem_have_inst, 0);
        idle_inputs();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Non-memory op: zero latency pass-through.
        set_op(0, 0, 2'b10, 0, 32'h55, 0, 1, 5'd3, 32'h40);
        push(32'h55, 1, 5'd3, 32'h40);
        #1;
        check("nm_req", dbus_req, 0);
        check("nm_stall", mem_stall, 0);
        next_cycle();
        idle_inputs();

        // lw 0x100 with immediate ack.
        set_op(1, 0, 2'b10, 0, 32'h100, 0, 1, 5'd5, 32'h1000);
        push(32'hDEADBEEF, 1, 5'd5, 32'h1000);
        #1;
        check("lw_addr", dbus_addr, 32'h100);
        check("lw_wen", dbus_wen, 4'b0000);
`ifdef MEM_MISALIGN_TRAP_EN
        check("lw_misalign", misalign, 0);
`endif
        mem_access(1, 32'hDEADBEEF);

        // Byte/half loads with sign and zero extension.
        set_op(1, 0, 2'b00, 0, 32'h103, 0, 1, 5'd6, 32'h1004);
        push(32'hFFFFFF80, 1, 5'd6, 32'h1004);
        mem_access(1, 32'h80123456);
        set_op(1, 0, 2'b00, 1, 32'h103, 0, 1, 5'd7, 32'h1008);
        push(32'h00000080, 1, 5'd7, 32'h1008);
        mem_access(1, 32'h80123456);
        set_op(1, 0, 2'b01, 0, 32'h102, 0, 1, 5'd8, 32'h100C);
        push(32'hFFFF8001, 1, 5'd8, 32'h100C);
        mem_access(1, 32'h80011234);
        set_op(1, 0, 2'b01, 1, 32'h100, 0, 1, 5'd9, 32'h1010);
        push(32'h0000ABCD, 1, 5'd9, 32'h1010);
        mem_access(1, 32'h1234ABCD);

        // Stores: lane enables and replicated data; never write back.
        set_op(0, 1, 2'b01, 0, 32'h102, 32'h00001234, 1, 5'd10, 32'h1014);
        push(32'h0, 0, 5'd10, 32'h1014);
        #1;
        check("sh_wen", dbus_wen, 4'b1100);
        check("sh_wdata", dbus_wdata, 32'h12341234);
        mem_access(1, 32'h0);
        set_op(0, 1, 2'b00, 0, 32'h105, 32'h000000A5, 1, 5'd11, 32'h1018);
        push(32'h0, 0, 5'd11, 32'h1018);
        #1;
        check("sb_addr", dbus_addr, 32'h104);
        check("sb_wen", dbus_wen, 4'b0010);
        check("sb_wdata", dbus_wdata, 32'hA5A5A5A5);
        mem_access(1, 32'h0);
        set_op(0, 1, 2'b10, 0, 32'h108, 32'hCAFEF00D, 0, 5'd12, 32'h101C);
        push(32'h0, 0, 5'd12, 32'h101C);
        #1;
        check("sw_wen", dbus_wen, 4'b1111);
        check("sw_wdata", dbus_wdata, 32'hCAFEF00D);
        mem_access(1, 32'h0);

        // lw acked on the 4th request cycle: three bubbles then completion.
        set_op(1, 0, 2'b10, 0, 32'h200, 0, 1, 5'd13, 32'h1020);
        push(32'h0BADF00D, 1, 5'd13, 32'h1020);
        mem_access(4, 32'h0BADF00D);

        // No ack: abort on the 16th request cycle.
        set_op(1, 0, 2'b10, 0, 32'h300, 0, 1, 5'd14, 32'h1024);
        push(32'h0, 0, 5'd14, 32'h1024);
        dbus_ack = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            #1;
            check("to_req", dbus_req, 1);
            check("to_err", bus_err, (k == 16) ? 1 : 0);
            check("to_stall", mem_stall, (k == 16) ? 0 : 1);
            if (k == 16) check("to_we", mem_we, 0);
            next_cycle();
        end
        idle_inputs();
        #1;
        check("to_req_after", dbus_req, 0);
        check("to_err_after", bus_err, 0);
        next_cycle();
        // State must be back in IDLE: a fresh access completes normally.
        set_op(1, 0, 2'b10, 0, 32'h304, 0, 1, 5'd15, 32'h1028);
        push(32'h13572468, 1, 5'd15, 32'h1028);
        mem_access(2, 32'h13572468);

        // Reset while waiting: request and stall drop immediately.
        set_op(1, 0, 2'b10, 0, 32'h400, 0, 1, 5'd16, 32'h102C);
        dbus_ack = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1;
        check("rw_req", dbus_req, 0);
        check("rw_stall", mem_stall, 0);
        check("rw_have_inst", mem_have_inst, 0);
        idle_inputs();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        set_op(1, 0, 2'b10, 0, 32'h404, 0, 1, 5'd17, 32'h1030);
        push(32'h2468ACE0, 1, 5'd17, 32'h1030);
        mem_access(1, 32'h2468ACE0);

`ifdef MEM_MISALIGN_TRAP_EN
        set_op(1, 0, 2'b10, 0, 32'h101, 0, 1, 5'd18, 32'h1034);
        push(32'h0, 0, 5'd18, 32'h1034);
        #1;
        check("mis_flag", misalign, 1);
        check("mis_req", dbus_req, 0);
        check("mis_stall", mem_stall, 0);
        next_cycle();
        idle_inputs();
`endif

        next_cycle();
        next_cycle();
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
